// File: rtl/serial_word_deser.sv
// Serial-to-parallel word deserializer with inter-bit gap timeout.
// Define SERIAL_WORD_DESER_LSB_FIRST_EN for LSB-first assembly (default MSB-first).
module serial_word_deser #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic             data_val_i,
    input  logic             data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             data_val_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WIDTH-2:0]   shift_q, shift_d, shift_nx;
    logic [WIDTH-1:0]   word_nx;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               dval_q, dval_d;
    logic               err_q, err_d;
    logic               gap_run;
    logic               tmo;

    // The partial register only ever holds WIDTH-1 bits; the final bit
    // is merged straight into the completed word.
`ifdef SERIAL_WORD_DESER_LSB_FIRST_EN
    assign word_nx  = {data_i, shift_q};
    assign shift_nx = word_nx[WIDTH-1:1];
`else
    assign word_nx  = {shift_q, data_i};
    assign shift_nx = word_nx[WIDTH-2:0];
`endif

    assign gap_run = (state_q == COLLECT) && !data_val_i;

    if (TIMEOUT > 0) begin : g_gap
        logic [GW-1:0] gap_q, gap_d;

        assign tmo = gap_run && (gap_q == GW'(TIMEOUT - 1));

        // Count idle cycles inside a partial word; any bit clears it.
        always_comb begin
            gap_d = '0;
            if (gap_run && !tmo) begin
                gap_d = gap_q + 1'b1;
            end
        end

        // Gap counter register.
        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                gap_q <= '0;
            end else begin
                gap_q <= gap_d;
            end
        end
    end else begin : g_nogap
        assign tmo = 1'b0;
    end

    // Next-state, shift and output-pulse decode.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dval_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_val_i) begin
                    shift_d   = shift_nx;
                    bit_cnt_d = BW'(1);
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                if (data_val_i) begin
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
                        data_d    = word_nx;
                        dval_d    = 1'b1;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        shift_d   = shift_nx;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (tmo) begin
                    err_d     = 1'b1;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            dval_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dval_q    <= dval_d;
            err_q     <= err_d;
        end
    end

    assign data_o     = data_q;
    assign data_val_o = dval_q;
    assign err_o      = err_q;
    assign busy_o     = (state_q == COLLECT);

endmodule

// File: tb/tb_serial_word_deser.sv
// Scoreboard bench for serial_word_deser (WIDTH=8, TIMEOUT=16).
// Expected words follow SERIAL_WORD_DESER_LSB_FIRST_EN when defined.
module tb_serial_word_deser;

    localparam int W  = 8;
    localparam int TO = 16;

`ifdef SERIAL_WORD_DESER_LSB_FIRST_EN
    localparam logic [7:0] E_B2 = 8'h4D;
    localparam logic [7:0] E_FF = 8'hFF;
    localparam logic [7:0] E_01 = 8'h80;
    localparam logic [7:0] E_96 = 8'h69;
    localparam logic [7:0] E_AE = 8'h75;
    localparam logic [7:0] E_C1 = 8'h83;
    localparam logic [7:0] E_A5 = 8'hA5;
`else
    localparam logic [7:0] E_B2 = 8'hB2;
    localparam logic [7:0] E_FF = 8'hFF;
    localparam logic [7:0] E_01 = 8'h01;
    localparam logic [7:0] E_96 = 8'h96;
    localparam logic [7:0] E_AE = 8'hAE;
    localparam logic [7:0] E_C1 = 8'hC1;
    localparam logic [7:0] E_A5 = 8'hA5;
`endif

    logic         clk = 1'b0;
    logic         arst_n_i = 1'b1;
    logic         data_val_i = 1'b0;
    logic         data_i = 1'b0;
    logic [W-1:0] data_o;
    logic         data_val_o;
    logic         err_o;
    logic         busy_o;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         pop;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    logic [7:0] last_w = 8'h00;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_word_deser #(
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk_i     (clk),
        .arst_n_i  (arst_n_i),
        .data_val_i(data_val_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .data_val_o(data_val_o),
        .err_o     (err_o),
        .busy_o    (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_val_o && err_o) chk("dval_err_excl", 32'd1, 32'd0);
            if (data_val_o || err_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {30'd0, data_val_o, err_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("kind", {31'd0, err_o}, {31'd0, e.is_err});
                    chk("latency", cyc, e.cyc);
                    chk("busy_on_pulse", {31'd0, busy_o}, 32'd0);
                    if (!e.is_err) begin
                        chk("word", {24'd0, data_o}, {24'd0, e.data});
                        chk("popcount", $countones(data_o), e.pop);
                        last_w = e.data;
                    end else begin
                        chk("data_hold_err", {24'd0, data_o}, {24'd0, last_w});
                    end
                end
            end else begin
                chk("data_hold", {24'd0, data_o}, {24'd0, last_w});
                if (sb.size() > 0 && cyc > sb[0].cyc) begin
                    chk("missing_out", 32'd0, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drv(input bit v, input bit b);
        @(negedge clk);
        data_val_i = v;
        data_i     = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0);
    endtask

    // Send tx[hi] down to tx[lo], optional random gaps before each bit.
    task automatic txbits(input logic [7:0] tx, input int hi, input int lo,
                          input int maxgap);
        for (int i = hi; i >= lo; i--) begin
            if (maxgap > 0 && i != hi) begin
                int g;
                g = $urandom_range(maxgap, 0);
                repeat (g) drv(1'b0, 1'b0);
            end
            drv(1'b1, tx[i]);
        end
    endtask

    task automatic expect_word(input logic [7:0] ex, input int pop);
        sb.push_back('{1'b0, ex, pop, cyc + 1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 arst_n_i = 1'b0;
        #1;
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_dval", {31'd0, data_val_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        repeat (2) @(negedge clk);
        arst_n_i = 1'b1;
        mon_en   = 1'b1;
        idle(2);

        // Single word, consecutive bits.
        txbits(8'hB2, 7, 0, 0);
        expect_word(E_B2, 4);
        idle(3);

        // Back-to-back words, 16 consecutive valid cycles.
        txbits(8'hFF, 7, 0, 0);
        expect_word(E_FF, 8);
        txbits(8'h01, 7, 0, 0);
        expect_word(E_01, 1);
        idle(3);

        // 3 bits then exactly TIMEOUT idle cycles -> err, then clean word.
        txbits(8'hC0, 7, 5, 0);
        drv(1'b0, 1'b0);
        chk("busy_partial", {31'd0, busy_o}, 32'd1);
        idle(TO - 1);
        sb.push_back('{1'b1, 8'h00, 0, cyc + 1});
        txbits(8'h96, 7, 0, 0);
        expect_word(E_96, 4);
        idle(3);

        // 3 bits, TIMEOUT-1 idle cycles, 5 bits -> single full word.
        txbits(8'hAE, 7, 5, 0);
        idle(TO - 1);
        txbits(8'hAE, 4, 0, 0);
        expect_word(E_AE, 5);
        idle(3);

        // Asynchronous reset mid-word.
        txbits(8'hFF, 7, 3, 0);
        drv(1'b0, 1'b0);
        chk("busy_before_rst", {31'd0, busy_o}, 32'd1);
        #2 arst_n_i = 1'b0;
        last_w = 8'h00;
        #1;
        chk("arst_data", {24'd0, data_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_err", {31'd0, err_o}, 32'd0);
        repeat (2) @(negedge clk);
        arst_n_i = 1'b1;
        txbits(8'hC1, 7, 0, 0);
        expect_word(E_C1, 3);
        idle(3);

        // Random gaps well below TIMEOUT.
        txbits(8'hA5, 7, 0, 5);
        expect_word(E_A5, 4);
        idle(5);

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
